// File: rtl/sext_arbiter.sv
// Round-robin arbiter sharing one sign-extension unit among four field requesters.
// Define SEXT_ARB_STATS_EN to compile in the per-port saturating accept counters (grant_cnt).
module sext_arbiter #(
  parameter int unsigned W0 = 5,
  parameter int unsigned W1 = 6,
  parameter int unsigned W2 = 9,
  parameter int unsigned W3 = 11
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  req_valid,
  input  logic [63:0] req_data,
  output logic [3:0]  req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic [1:0]  resp_id
`ifdef SEXT_ARB_STATS_EN
  ,
  output logic [31:0] grant_cnt
`endif
);

  function automatic logic [15:0] sext_field(input logic [15:0] raw, input int unsigned width);
    logic [15:0] res;
    logic [3:0]  msb;
    res = 16'h0000;
    msb = 4'(width - 32'd1);
    for (int unsigned b = 0; b < 32'd16; b++) begin
      if (b < width) begin
        res[b] = raw[b];
      end else begin
        res[b] = raw[msb];
      end
    end
    return res;
  endfunction

  function automatic int unsigned port_width(input logic [1:0] idx);
    int unsigned w;
    case (idx)
      2'd0:    w = W0;
      2'd1:    w = W1;
      2'd2:    w = W2;
      2'd3:    w = W3;
      default: w = W0;
    endcase
    return w;
  endfunction

  logic        resp_valid_q, resp_valid_d;
  logic [15:0] resp_data_q, resp_data_d;
  logic [1:0]  resp_id_q, resp_id_d;
  logic [1:0]  ptr_q, ptr_d;
  logic        grant_found_s;
  logic [1:0]  grant_idx_s;
  logic [1:0]  cand_s;
  logic        slot_open_s;
  logic        accept_s;
  logic [15:0] raw_s;

  // Rotating priority search starting at ptr_q; first valid port wins.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = ptr_q;
    cand_s        = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand_s = ptr_q + 2'(k);
      if (!grant_found_s && req_valid[cand_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // A new result may be loaded when the register is empty or is draining this cycle.
  always_comb begin
    slot_open_s = !resp_valid_q || resp_ready;
    accept_s    = grant_found_s && slot_open_s;
    raw_s       = req_data[{grant_idx_s, 4'b0000} +: 16];
    if (accept_s) begin
      req_ready = 4'b0001 << grant_idx_s;
    end else begin
      req_ready = 4'b0000;
    end
  end

  // Next state of the result register and round-robin pointer.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    ptr_d        = ptr_q;
    if (accept_s) begin
      resp_valid_d = 1'b1;
      resp_data_d  = sext_field(raw_s, port_width(grant_idx_s));
      resp_id_d    = grant_idx_s;
      ptr_d        = grant_idx_s + 2'd1;
    end else if (resp_valid_q && resp_ready) begin
      resp_valid_d = 1'b0;
    end else begin
      resp_valid_d = resp_valid_q;
    end
  end

  // Result register and pointer state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= 16'h0000;
      resp_id_q    <= 2'b00;
      ptr_q        <= 2'b00;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      ptr_q        <= ptr_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;

`ifdef SEXT_ARB_STATS_EN
  logic [31:0] cnt_q;

  // Per-port accept counters, saturating at 8'hFF.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 32'h0000_0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept_s && (grant_idx_s == 2'(i)) && (cnt_q[8*i +: 8] != 8'hFF)) begin
          cnt_q[8*i +: 8] <= cnt_q[8*i +: 8] + 8'd1;
        end else begin
          cnt_q[8*i +: 8] <= cnt_q[8*i +: 8];
        end
      end
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule
